// File: rtl/scan_mem_pkg.sv
// Shared types and frame field offsets for the scan-driven SRAM access controller.
package scan_mem_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] ST_OK  = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;
  localparam logic [1:0] ST_ERR = 2'b11;

  localparam int OP_LSB   = 0;
  localparam int ID_BIT   = 2;
  localparam int SEG_LSB  = 3;
  localparam int ADDR_LSB = 5;
  localparam int DATA_LSB = 16;

endpackage

// File: rtl/scan_shift_reg.sv
// Frame register: LSB-first serial shift, or a masked parallel load of selected fields.
module scan_shift_reg #(
  parameter int FW = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_en,
  input  logic          scan_in,
  input  logic          load_en,
  input  logic [FW-1:0] load_mask,
  input  logic [FW-1:0] load_val,
  output logic [FW-1:0] sr
);

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= {scan_in, sr[FW-1:1]};
    end else if (load_en) begin
      sr <= (sr & ~load_mask) | (load_val & load_mask);
    end
  end

endmodule

// File: rtl/scan_mem_ctrl.sv
// Executes one scanned-in read/write frame against the SRAM request port and
// loads status (and read data) back into the frame register for shift-out.
module scan_mem_ctrl
  import scan_mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic              scan_in,
  output logic              scan_out,
  input  logic              update,
  output logic              busy,
  output logic              done,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [1:0]        mem_seg_id,
  output logic              mem_id_sel,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ready
);

  localparam int FW    = DATA_LSB + WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [FW-1:0]    sr, load_mask, load_val;
  logic             shift_en, load_en, is_wr, start, is_access, tmo;
  op_e              op;

  assign op        = op_e'(sr[OP_LSB +: 2]);
  assign start     = (state == IDLE) && !scan_en && update;
  assign is_access = (op == OP_WR) || (op == OP_RD);
  assign tmo       = (cnt == CNT_W'(TIMEOUT - 1));
  assign shift_en  = (state == IDLE) && scan_en;

  scan_shift_reg #(.FW(FW)) u_sr (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .scan_in   (scan_in),
    .load_en   (load_en),
    .load_mask (load_mask),
    .load_val  (load_val),
    .sr        (sr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_wr      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_seg_id <= '0;
      mem_id_sel <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start && is_access) begin
        cnt        <= '0;
        is_wr      <= (op == OP_WR);
        mem_addr   <= sr[ADDR_LSB +: ADDR_W];
        mem_wdata  <= sr[DATA_LSB +: WIDTH];
        mem_seg_id <= sr[SEG_LSB +: 2];
        mem_id_sel <= sr[ID_BIT];
      end else if (state == REQ && !mem_ready && cnt < CNT_W'(TIMEOUT)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    load_mask = '0;
    load_val  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_access) begin
            state_nxt = REQ;
          end else if (op == OP_RSVD) begin
            state_nxt              = DONE;
            load_en                = 1'b1;
            load_mask[OP_LSB +: 2] = 2'b11;
            load_val[OP_LSB +: 2]  = ST_ERR;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_nxt              = DONE;
          load_en                = 1'b1;
          load_mask[OP_LSB +: 2] = 2'b11;
          load_val[OP_LSB +: 2]  = ST_OK;
          if (!is_wr) begin
            load_mask[DATA_LSB +: WIDTH] = '1;
            load_val[DATA_LSB +: WIDTH]  = mem_rdata;
          end
        end else if (tmo) begin
          // Ready on the final count is handled above, so it wins over timeout.
          state_nxt              = DONE;
          load_en                = 1'b1;
          load_mask[OP_LSB +: 2] = 2'b11;
          load_val[OP_LSB +: 2]  = ST_TMO;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_cen  = (state == REQ);
  assign mem_wen  = mem_cen && is_wr;
  assign mem_ren  = mem_cen && !is_wr;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign scan_out = sr[0];

endmodule
